// File: rtl/fp_align_stage.sv
// fp_align_stage: registered alignment stage of the pipelined FP add/sub path.
// Works out the effective operation and orders the operands by magnitude.
// It right-aligns the smaller mantissa with guard/round/sticky bits and
// one's-complements it on an effective subtract. The results are presented
// behind a valid/ready handshake so the stage can stall.
// Optional build macro: FP_ALIGN_SKID_EN adds a one-entry skid register so
// that o_in_ready is registered, with no combinational path from i_out_ready.
module fp_align_stage #(
    parameter int ExponentSize = 8,
    parameter int FractionSize = 23
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic                            i_sign1,
    input  logic                            i_sign2,
    input  logic [ExponentSize-1:0]         i_exponent1,
    input  logic [ExponentSize-1:0]         i_exponent2,
    input  logic [FractionSize:0]           i_mantissa1,
    input  logic [FractionSize:0]           i_mantissa2,
    input  logic                            i_operation,
    output logic                            o_out_valid,
    input  logic                            i_out_ready,
    output logic [FractionSize+3:0]         o_adder1,
    output logic [FractionSize+3:0]         o_adder2,
    output logic                            o_carry_in,
    output logic [ExponentSize-1:0]         o_exponent_base,
    output logic                            o_result_sign,
    output logic                            o_eff_operation,
    output logic                            o_zero_result
);

    localparam int MantissaSize = FractionSize + 1;
    localparam int RoundingSize = MantissaSize + 3;
    localparam int PayloadSize  = 2 * RoundingSize + ExponentSize + 4;

    logic                      w_sign2_eff;
    logic                      w_eff_op;
    logic                      w_exp_eq;
    logic                      w_mant_eq;
    logic                      w_a_big;
    logic [ExponentSize-1:0]   w_exp_big;
    logic [ExponentSize-1:0]   w_exp_small;
    logic [MantissaSize-1:0]   w_mant_big;
    logic [MantissaSize-1:0]   w_mant_small;
    logic [ExponentSize-1:0]   w_diff;
    logic [31:0]               w_diff_ext;
    logic [31:0]               w_shamt;
    logic [RoundingSize-2:0]   w_p;
    logic [RoundingSize-2:0]   w_q;
    logic [RoundingSize-2:0]   w_mask;
    logic                      w_sticky;
    logic [RoundingSize-1:0]   w_aligned;
    logic [RoundingSize-1:0]   w_adder1;
    logic [RoundingSize-1:0]   w_adder2;
    logic                      w_zero;
    logic                      w_rsign;
    logic [PayloadSize-1:0]    w_payload;
    logic                      w_in_xfer;
    logic                      w_out_xfer;

    logic [PayloadSize-1:0]    r_out;
    logic                      r_out_valid;

    assign w_sign2_eff  = i_sign2 ^ i_operation;
    assign w_eff_op     = i_sign1 ^ w_sign2_eff;
    assign w_exp_eq     = (i_exponent1 == i_exponent2);
    assign w_mant_eq    = (i_mantissa1 == i_mantissa2);
    // Ties on magnitude go to A, so the difference is never negative.
    assign w_a_big      = (i_exponent1 > i_exponent2) ||
                          (w_exp_eq && (i_mantissa1 >= i_mantissa2));
    assign w_exp_big    = w_a_big ? i_exponent1 : i_exponent2;
    assign w_exp_small  = w_a_big ? i_exponent2 : i_exponent1;
    assign w_mant_big   = w_a_big ? i_mantissa1 : i_mantissa2;
    assign w_mant_small = w_a_big ? i_mantissa2 : i_mantissa1;

    // Clamp the shift so that large exponent gaps collapse into the sticky bit.
    assign w_diff     = w_exp_big - w_exp_small;
    assign w_diff_ext = {{(32 - ExponentSize){1'b0}}, w_diff};
    assign w_shamt    = (w_diff_ext >= 32'(RoundingSize - 1)) ? 32'(RoundingSize - 1) : w_diff_ext;

    assign w_p       = {w_mant_small, 2'b00};
    assign w_q       = w_p >> w_shamt;
    assign w_mask    = ~({(RoundingSize - 1){1'b1}} << w_shamt);
    assign w_sticky  = |(w_p & w_mask);
    assign w_aligned = {w_q, w_sticky};

    assign w_adder1 = w_eff_op ? ~w_aligned : w_aligned;
    assign w_adder2 = {w_mant_big, 3'b000};
    assign w_zero   = w_eff_op && w_exp_eq && w_mant_eq;
    // An exact cancellation gives +0 under round-to-nearest.
    assign w_rsign  = w_zero ? 1'b0 : (w_a_big ? i_sign1 : w_sign2_eff);

    assign w_payload = {w_adder1, w_adder2, w_eff_op, w_exp_big, w_rsign, w_eff_op, w_zero};

    assign w_in_xfer  = i_in_valid && o_in_ready;
    assign w_out_xfer = r_out_valid && i_out_ready;

    assign o_out_valid = r_out_valid;
    assign {o_adder1, o_adder2, o_carry_in, o_exponent_base,
            o_result_sign, o_eff_operation, o_zero_result} = r_out;

`ifdef FP_ALIGN_SKID_EN
    logic [PayloadSize-1:0]    r_skid;
    logic                      r_skid_full;

    assign o_in_ready = !r_skid_full;

    // Output register plus skid: the skid drains first, so order is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_skid      <= '0;
            r_skid_full <= 1'b0;
        end else if (r_skid_full) begin
            if (w_out_xfer) begin
                r_out       <= r_skid;
                r_skid_full <= 1'b0;
            end
        end else if (!r_out_valid || w_out_xfer) begin
            r_out_valid <= w_in_xfer;
            if (w_in_xfer) begin
                r_out <= w_payload;
            end
        end else if (w_in_xfer) begin
            r_skid      <= w_payload;
            r_skid_full <= 1'b1;
        end
    end
`else
    assign o_in_ready = !r_out_valid || i_out_ready;

    // Single output register: load on input transfer, drop valid once drained.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_in_xfer) begin
            r_out       <= w_payload;
            r_out_valid <= 1'b1;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage using directed vectors with hand-computed results.
module tb_fp_align_stage;

    typedef struct {
        logic        s1, s2;
        logic [7:0]  e1, e2;
        logic [23:0] m1, m2;
        logic        op;
        logic [26:0] a1, a2;
        logic        cin;
        logic [7:0]  eb;
        logic        rs, eff, z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign1 = 1'b0, sign2 = 1'b0, operation = 1'b0;
    logic [7:0]  exp1 = '0, exp2 = '0;
    logic [23:0] mant1 = '0, mant2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [26:0] adder1, adder2;
    logic        carry_in, result_sign, eff_operation, zero_result;
    logic [7:0]  exponent_base;

    int   total = 0;
    int   bad = 0;
    int   out_n = 0;
    vec_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    fp_align_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_sign1(sign1), .i_sign2(sign2), .i_exponent1(exp1), .i_exponent2(exp2),
        .i_mantissa1(mant1), .i_mantissa2(mant2), .i_operation(operation),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_adder1(adder1), .o_adder2(adder2), .o_carry_in(carry_in),
        .o_exponent_base(exponent_base), .o_result_sign(result_sign),
        .o_eff_operation(eff_operation), .o_zero_result(zero_result)
    );

    function automatic vec_t mk(logic s1, logic s2, logic [7:0] e1, logic [23:0] m1,
                                logic [7:0] e2, logic [23:0] m2, logic op,
                                logic [26:0] a1, logic [26:0] a2, logic cin,
                                logic [7:0] eb, logic rs, logic eff, logic z);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.e1 = e1; v.e2 = e2; v.m1 = m1; v.m2 = m2; v.op = op;
        v.a1 = a1; v.a2 = a2; v.cin = cin; v.eb = eb; v.rs = rs; v.eff = eff; v.z = z;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        sign1 = v.s1; sign2 = v.s2; exp1 = v.e1; exp2 = v.e2;
        mant1 = v.m1; mant2 = v.m2; operation = v.op;
    endtask

    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        apply(v);
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sb.push_back(v);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((sb.size() != 0 || out_valid) && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compares each output transfer against the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out%0d unexpected output a1=%h", out_n, adder1);
            end else begin
                vec_t e;
                e = sb.pop_front();
                total++;
                if (adder1 !== e.a1 || adder2 !== e.a2 || carry_in !== e.cin ||
                    exponent_base !== e.eb || result_sign !== e.rs ||
                    eff_operation !== e.eff || zero_result !== e.z) begin
                    bad++;
                    $display("FAIL out%0d got a1=%h a2=%h cin=%b eb=%0d rs=%b eff=%b z=%b want a1=%h a2=%h cin=%b eb=%0d rs=%b eff=%b z=%b",
                             out_n, adder1, adder2, carry_in, exponent_base, result_sign,
                             eff_operation, zero_result, e.a1, e.a2, e.cin, e.eb, e.rs, e.eff, e.z);
                end
            end
            out_n++;
        end
    end

    initial begin
        logic [26:0] snap_a1, snap_a2;
        logic [7:0]  snap_eb;
        int          idx, acc, exp_acc;

        vecs[0]  = mk(0, 0, 8'd127, 24'hC00000, 8'd127, 24'h800000, 0, 27'h4000000, 27'h6000000, 0, 8'd127, 0, 0, 0);
        vecs[1]  = mk(0, 0, 8'd127, 24'h800000, 8'd127, 24'hC00000, 1, 27'h3FFFFFF, 27'h6000000, 1, 8'd127, 1, 1, 0);
        vecs[2]  = mk(0, 0, 8'd130, 24'h800000, 8'd127, 24'h800001, 0, 27'h0800001, 27'h4000000, 0, 8'd130, 0, 0, 0);
        vecs[3]  = mk(0, 0, 8'd150, 24'hA00000, 8'd100, 24'h800123, 0, 27'h0000001, 27'h5000000, 0, 8'd150, 0, 0, 0);
        vecs[4]  = mk(0, 0, 8'd127, 24'h900000, 8'd127, 24'h900000, 1, 27'h37FFFFF, 27'h4800000, 1, 8'd127, 0, 1, 1);
        vecs[5]  = mk(1, 0, 8'd128, 24'h800000, 8'd127, 24'h800000, 0, 27'h5FFFFFF, 27'h4000000, 1, 8'd128, 1, 1, 0);
        vecs[6]  = mk(1, 1, 8'd127, 24'h800000, 8'd129, 24'hC00000, 1, 27'h6FFFFFF, 27'h6000000, 1, 8'd129, 0, 1, 0);
        vecs[7]  = mk(0, 0, 8'd153, 24'h800000, 8'd127, 24'h800000, 0, 27'h0000001, 27'h4000000, 0, 8'd153, 0, 0, 0);
        vecs[8]  = mk(0, 0, 8'd152, 24'h800000, 8'd127, 24'h800000, 0, 27'h0000002, 27'h4000000, 0, 8'd152, 0, 0, 0);
        vecs[9]  = mk(1, 1, 8'd127, 24'h800000, 8'd127, 24'h800000, 0, 27'h4000000, 27'h4000000, 0, 8'd127, 1, 0, 0);
        vecs[10] = mk(0, 0, 8'd130, 24'hFFFFFF, 8'd127, 24'h800007, 0, 27'h0800007, 27'h7FFFFF8, 0, 8'd130, 0, 0, 0);

        // Reset state
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_adder1", 32'(adder1), 32'd0);
        check("rst_adder2", 32'(adder2), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors back to back, no backpressure
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) send(vecs[i]);
        drain();

        // Stall with a new operand offered every cycle
`ifdef FP_ALIGN_SKID_EN
        exp_acc = 2;
`else
        exp_acc = 1;
`endif
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        snap_a1 = '0; snap_a2 = '0; snap_eb = '0;
        for (int c = 0; c < 5; c++) begin
            apply(vecs[idx]);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(vecs[idx]);
                acc++;
                idx++;
            end
            if (c == 1) begin
                snap_a1 = adder1; snap_a2 = adder2; snap_eb = exponent_base;
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_first_a1", 32'(snap_a1), 32'(vecs[0].a1));
            end else if (c >= 2) begin
                check("stall_hold_a1", 32'(adder1), 32'(snap_a1));
                check("stall_hold_a2", 32'(adder2), 32'(snap_a2));
                check("stall_hold_eb", 32'(exponent_base), 32'(snap_eb));
            end
            if (c == 4) check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stall_accepted", 32'(acc), 32'(exp_acc));
        out_ready = 1'b1;
        drain();

        // Asynchronous reset while stalled with valid output
        out_ready = 1'b0;
        send(vecs[5]);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_adder1", 32'(adder1), 32'd0);
        check("async_rst_adder2", 32'(adder2), 32'd0);
        check("async_rst_eb", 32'(exponent_base), 32'd0);
        check("async_rst_flags", 32'({carry_in, result_sign, eff_operation, zero_result}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(vecs[2]);
        check("post_rst_latency", 32'(out_valid), 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
